// File: rtl/trng_pkg.sv
// Shared constants, FSM state type and LFSR step function for the TRNG arbiter.
package trng_pkg;

  localparam int unsigned         LFSR_W          = 16;
  localparam logic [LFSR_W-1:0]   LFSR_RESET_SEED = 16'hACE1;
  // Feedback taps at bits 0, 2, 3 and 5.
  localparam logic [LFSR_W-1:0]   LFSR_TAPS       = 16'h002D;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_DELIVER = 2'd2
  } trng_state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] r);
    return {^(r & LFSR_TAPS), r[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with seed load; an all-zero seed is replaced by the reset seed.
module lfsr16
  import trng_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        step,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] q
);

  logic [LFSR_W-1:0] r_q, r_d;

  always_comb begin
    r_d = r_q;
    if (load) begin
      r_d = (load_val == '0) ? LFSR_RESET_SEED : load_val;
    end else if (step) begin
      r_d = lfsr_next(r_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= LFSR_RESET_SEED;
    end else begin
      r_q <= r_d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/trng_arbiter.sv
// Round-robin arbiter handing out WORD_W-bit words drawn serially from a shared LFSR.
module trng_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned WORD_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   grant,
  output logic [WORD_W-1:0] rnd_data,
  output logic              rnd_valid,
  input  logic              seed_load,
  input  logic [15:0]       seed_data,
  output logic              busy
);
  import trng_pkg::*;

  localparam int unsigned IDX_W = $clog2(NREQ);
  localparam int unsigned CNT_W = $clog2(WORD_W + 2);

  trng_state_e       state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] data_q, data_d;

  logic [LFSR_W-1:0] lfsr_q;
  logic              lfsr_step;
  logic              lfsr_load;

  logic              hit_hi, hit_lo;
  logic [IDX_W-1:0]  idx_hi, idx_lo;
  logic [IDX_W-1:0]  rr_idx;

  lfsr16 u_lfsr (
    .clk      (clk),
    .reset_n  (reset_n),
    .step     (lfsr_step),
    .load     (lfsr_load),
    .load_val (seed_data),
    .q        (lfsr_q)
  );

  // Round-robin pick: lowest set bit at or above ptr, else lowest set bit overall.
  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (req[j] && (j >= 32'(ptr_q)) && !hit_hi) begin
        hit_hi = 1'b1;
        idx_hi = IDX_W'(j);
      end
      if (req[j] && !hit_lo) begin
        hit_lo = 1'b1;
        idx_lo = IDX_W'(j);
      end
    end
    rr_idx = hit_hi ? idx_hi : idx_lo;
  end

  // DELIVER spans two cycles: a settle cycle (cnt == WORD_W) then the valid cycle,
  // giving rnd_valid one cycle after edge k+1+WORD_W for a grant taken at edge k.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    lfsr_step = 1'b0;
    lfsr_load = 1'b0;
    rnd_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (seed_load) begin
          lfsr_load = 1'b1;
        end else if (req != '0) begin
          grant_d = NREQ'(1'b1) << rr_idx;
          idx_d   = rr_idx;
          cnt_d   = '0;
          data_d  = '0;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (!req[idx_q]) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end else begin
          lfsr_step = 1'b1;
          data_d    = data_q << 1;
          data_d[0] = lfsr_q[0];
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WORD_W - 1)) begin
            state_d = ST_DELIVER;
          end
        end
      end
      ST_DELIVER: begin
        if (cnt_q == CNT_W'(WORD_W)) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          rnd_valid = 1'b1;
          ptr_d     = (idx_q == IDX_W'(NREQ - 1)) ? '0 : idx_q + 1'b1;
          grant_d   = '0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign grant    = grant_q;
  assign rnd_data = data_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_trng_arbiter.sv
// Directed and randomized bench for trng_arbiter against a word-level reference model.
module tb_trng_arbiter;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned WORD_W = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   grant;
  logic [WORD_W-1:0] rnd_data;
  logic              rnd_valid;
  logic              seed_load;
  logic [15:0]       seed_data;
  logic              busy;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  logic [15:0] mdl_r;
  int unsigned mdl_ptr;

  always #5 clk = ~clk;

  trng_arbiter #(.NREQ(NREQ), .WORD_W(WORD_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .grant     (grant),
    .rnd_data  (rnd_data),
    .rnd_valid (rnd_valid),
    .seed_load (seed_load),
    .seed_data (seed_data),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the random bit stream is r[0] of successive LFSR states; a word is
  // WORD_W consecutive stream bits, oldest bit in the MSB.
  task automatic mdl_advance(input int unsigned n, output logic [WORD_W-1:0] w);
    logic fb;
    w = '0;
    for (int unsigned i = 0; i < n; i++) begin
      w     = (w << 1) | WORD_W'(mdl_r[0]);
      fb    = mdl_r[0] ^ mdl_r[2] ^ mdl_r[3] ^ mdl_r[5];
      mdl_r = {fb, mdl_r[15:1]};
    end
  endtask

  function automatic int unsigned mdl_pick(input logic [NREQ-1:0] r);
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (r[(mdl_ptr + i) % NREQ]) return (mdl_ptr + i) % NREQ;
    end
    return 0;
  endfunction

  task automatic do_reset();
    reset_n   = 1'b0;
    req       = '0;
    seed_load = 1'b0;
    #1;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_valid", 32'(rnd_valid), 32'h0);
    check("rst_data", 32'(rnd_data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    tick();
    reset_n = 1'b1;
    mdl_r   = 16'hACE1;
    mdl_ptr = 0;
  endtask

  task automatic do_txn(input logic [NREQ-1:0] r, input bit drop, input bit seed_in_fill,
                        output logic [NREQ-1:0] g, output logic [WORD_W-1:0] w);
    int unsigned       exp_idx;
    logic [WORD_W-1:0] exp_w;
    logic [NREQ-1:0]   exp_g;
    int unsigned       n;
    bit                seen;
    exp_idx = mdl_pick(r);
    exp_g   = NREQ'(1) << exp_idx;
    mdl_advance(WORD_W, exp_w);
    req = r;
    tick();
    check("arb_grant", 32'(grant), 32'(exp_g));
    check("arb_busy", 32'(busy), 32'h1);
    if (seed_in_fill) begin
      seed_load = 1'b1;
      seed_data = 16'($urandom);
    end
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (rnd_valid) seen = 1'b1;
    end
    seed_load = 1'b0;
    check("valid_latency", n, WORD_W + 1);
    check("valid_grant", 32'(grant), 32'(exp_g));
    check("valid_word", 32'(rnd_data), 32'(exp_w));
    g       = grant;
    w       = rnd_data;
    mdl_ptr = (exp_idx + 1) % NREQ;
    if (drop) req = '0;
    tick();
    check("post_valid", 32'(rnd_valid), 32'h0);
    check("post_grant", 32'(grant), 32'h0);
    check("post_busy", 32'(busy), 32'h0);
    check("post_data_hold", 32'(rnd_data), 32'(exp_w));
    check("post_lfsr", 32'(dut.u_lfsr.q), 32'(mdl_r));
  endtask

  task automatic seed_op(input logic [15:0] s, input logic [NREQ-1:0] r);
    seed_load = 1'b1;
    seed_data = s;
    req       = r;
    tick();
    seed_load = 1'b0;
    check("seed_defers_grant", 32'(grant), 32'h0);
    check("seed_idle", 32'(busy), 32'h0);
    mdl_r = (s == 16'h0) ? 16'hACE1 : s;
  endtask

  task automatic abort_op(input logic [NREQ-1:0] r, input int unsigned nsteps);
    int unsigned       exp_idx;
    logic [WORD_W-1:0] dummy;
    bit                any_valid;
    exp_idx = mdl_pick(r);
    req     = r;
    tick();
    check("abort_grant", 32'(grant), 32'(NREQ'(1) << exp_idx));
    repeat (nsteps) tick();
    req = '0;
    tick();
    check("abort_grant_clr", 32'(grant), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    any_valid = 1'b0;
    repeat (WORD_W + 2) begin
      tick();
      if (rnd_valid) any_valid = 1'b1;
    end
    check("abort_no_valid", 32'(any_valid), 32'h0);
    mdl_advance(nsteps, dummy);
  endtask

  initial begin
    logic [NREQ-1:0]   g;
    logic [WORD_W-1:0] w;
    logic [NREQ-1:0]   r;
    logic [15:0]       s;
    logic [NREQ-1:0]   rr_order [5];
    bit                any_valid;

    rr_order[0] = 4'b0001;
    rr_order[1] = 4'b0010;
    rr_order[2] = 4'b0100;
    rr_order[3] = 4'b1000;
    rr_order[4] = 4'b0001;

    reset_n   = 1'b0;
    req       = '0;
    seed_load = 1'b0;
    seed_data = '0;
    mdl_r     = 16'hACE1;
    mdl_ptr   = 0;
    repeat (2) tick();
    check("init_grant", 32'(grant), 32'h0);
    check("init_valid", 32'(rnd_valid), 32'h0);
    check("init_data", 32'(rnd_data), 32'h0);
    check("init_busy", 32'(busy), 32'h0);
    check("init_lfsr", 32'(dut.u_lfsr.q), 32'hACE1);
    reset_n = 1'b1;

    // Reset seed, single requester held: known first two words.
    do_txn(4'b0001, 1'b0, 1'b0, g, w);
    check("first_word_87", 32'(w), 32'h87);
    do_txn(4'b0001, 1'b1, 1'b0, g, w);
    check("second_word_35", 32'(w), 32'h35);

    // All requesters held continuously: strict rotation.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_txn(4'b1111, (i == 4), 1'b0, g, w);
      check("rr_order", 32'(g), 32'(rr_order[i]));
    end

    // Zero seed substitutes the reset seed.
    do_txn(4'b0010, 1'b1, 1'b0, g, w);
    seed_op(16'h0000, 4'b0000);
    do_txn(4'b0001, 1'b1, 1'b0, g, w);
    check("zero_seed_word", 32'(w), 32'h87);

    // Seed load wins over a simultaneous request.
    seed_op(16'h1234, 4'b0100);
    do_txn(4'b0100, 1'b1, 1'b0, g, w);

    // Abort after three FILL cycles keeps the consumed bits.
    abort_op(4'b1000, 3);
    do_txn(4'b1000, 1'b1, 1'b0, g, w);

    // Reset in FILL cycle 5 discards the word.
    req = 4'b0010;
    tick();
    repeat (4) tick();
    #2;
    do_reset();
    any_valid = 1'b0;
    repeat (WORD_W + 3) begin
      tick();
      if (rnd_valid) any_valid = 1'b1;
    end
    check("rst_fill_no_valid", 32'(any_valid), 32'h0);
    do_txn(4'b0001, 1'b1, 1'b0, g, w);
    check("rst_fill_word", 32'(w), 32'h87);

    // Seed load while filling is ignored.
    do_txn(4'b0110, 1'b1, 1'b1, g, w);

    for (int i = 0; i < 30; i++) begin
      r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      case ($urandom_range(0, 3))
        0: do_txn(r, 1'b1, 1'b0, g, w);
        1: begin
          s = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
          seed_op(s, r);
          do_txn(r, 1'b1, 1'b0, g, w);
        end
        2: abort_op(r, $urandom_range(0, WORD_W - 1));
        default: do_txn(r, 1'b1, 1'b1, g, w);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
